// File: rtl/gen3_lane_scrambler.sv
// -----------------------------------------------------------------------------
// gen3_lane_scrambler
//
// Per-lane 128b/130b scrambler with an integrated 23-bit Galois LFSR and a
// single-register valid/ready output stage.
//
// Each accepted beat carries BYTES symbols, with byte 0 earliest on the wire.
// Every symbol is XORed bit-serially, LSB first, with the lane keystream. The
// bytes are chained combinationally through one LFSR state.
//   - skip_i[i]          : SKP symbol. It passes unchanged and the LFSR holds.
//   - datak_i[i]         : K/ordered-set symbol. It passes unchanged and the
//                          LFSR advances 8 bits.
//   - scramble_enable_i  : when 0, every byte passes unchanged. The LFSR
//                          advances exactly as it would when enabled.
//   - lfsr_reset_i       : reloads the lane seed. A beat accepted in the same
//                          cycle is still scrambled with the pre-reset state.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   valid_i / ready_o         input handshake (ready_o = ~valid_o | ready_i)
//   data_i, datak_i, skip_i   input beat and per-byte controls
//   scramble_enable_i         global scramble enable
//   lfsr_reset_i              reload LFSR with the lane seed
//   valid_o / ready_i         output handshake
//   data_o, datak_o           registered scrambled beat, datak_i | skip_i
//   lfsr_state_o              current LFSR state
// -----------------------------------------------------------------------------
module gen3_lane_scrambler #(
    parameter int BYTES    = 4,
    parameter int LANE_NUM = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [8*BYTES-1:0] data_i,
    input  logic [BYTES-1:0]   datak_i,
    input  logic [BYTES-1:0]   skip_i,
    input  logic               scramble_enable_i,
    input  logic               lfsr_reset_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [8*BYTES-1:0] data_o,
    output logic [BYTES-1:0]   datak_o,
    output logic [22:0]        lfsr_state_o
);

    // Feedback taps for x^23+x^21+x^16+x^8+x^5+x^2+1 in Galois form.
    localparam logic [22:0] POLY = 23'h210125;

    function automatic logic [22:0] lane_seed(input int lane);
        logic [22:0] seed;
        case (lane % 8)
            0:       seed = 23'h1DBFBC;
            1:       seed = 23'h0607BB;
            2:       seed = 23'h1EC760;
            3:       seed = 23'h18C0DB;
            4:       seed = 23'h010F12;
            5:       seed = 23'h19CFC9;
            6:       seed = 23'h0277CE;
            default: seed = 23'h1BB807;
        endcase
        return seed;
    endfunction

    localparam logic [22:0] SEED = lane_seed(LANE_NUM);

    logic [22:0]        lfsr_q, lfsr_d;
    logic               valid_q, valid_d;
    logic [8*BYTES-1:0] data_q, data_d;
    logic [BYTES-1:0]   datak_q, datak_d;

    logic [22:0]        chain_state;
    logic [8*BYTES-1:0] scrambled;
    logic               accept;

    // ready_o depends only on the output register and ready_i, never on valid_i.
    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    // Scramble the whole beat by walking one LFSR state through every
    // non-skipped byte. chain_state ends as the state after the last
    // non-skipped byte.
    // NOTE: blocking assignments are intentional here. chain_state must update
    // bit by bit within the same evaluation so each step sees the previous one.
    always_comb begin
        chain_state = lfsr_q;
        scrambled   = data_i;
        for (int i = 0; i < BYTES; i++) begin
            if (!skip_i[i]) begin
                for (int b = 0; b < 8; b++) begin
                    scrambled[8*i+b] = data_i[8*i+b]
                                     ^ (chain_state[22] & scramble_enable_i & ~datak_i[i]);
                    chain_state      = {chain_state[21:0], 1'b0}
                                     ^ (chain_state[22] ? POLY : 23'h0);
                end
            end
        end
    end

    // Next-state logic for the LFSR and the output register.
    // NOTE: every _d signal takes its hold value first, so no path through
    // this block can infer a latch.
    always_comb begin
        lfsr_d  = lfsr_q;
        valid_d = valid_q;
        data_d  = data_q;
        datak_d = datak_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = scrambled;
            datak_d = datak_i | skip_i;
            lfsr_d  = chain_state;
        end else if (ready_i) begin
            // The downstream took the held beat and nothing replaces it.
            valid_d = 1'b0;
        end
        // A reload wins over the advance. The beat above was already
        // scrambled with the old state.
        if (lfsr_reset_i) begin
            lfsr_d = SEED;
        end
    end

    // NOTE: the state registers use non-blocking assignments, so every flop
    // samples its _d value from before this clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            data_q  <= '0;
            datak_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            datak_q <= datak_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign datak_o      = datak_q;
    assign lfsr_state_o = lfsr_q;

endmodule

// File: doc/gen3_lane_scrambler.md
# gen3_lane_scrambler

Parametrised, registered PCIe Gen3 (128b/130b) per-lane scrambler with an integrated 23-bit LFSR. Each cycle it accepts a beat of BYTES symbols and scrambles every eligible byte with the lane's keystream. Per-byte controls let K/ordered-set bytes bypass scrambling and let SKP bytes freeze the LFSR. It sits between the lane's block framer and the 130b gearbox, and adds a valid/ready output stage with backpressure.

## Interface
- BYTES, 4, symbols per beat; legal values 1, 2, 4, 8.
- LANE_NUM, 0, physical lane number 0..31; selects the seed via LANE_NUM mod 8.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  input beat present.
- ready_o  out  1  input beat accepted when valid_i & ready_o.
- data_i  in  8*BYTES  symbols; byte i = data_i[8i+7:8i]; byte 0 is earliest on the wire.
- datak_i  in  BYTES  byte i is sent unscrambled; the LFSR still advances 8 bits.
- skip_i  in  BYTES  byte i is a SKP symbol: sent unscrambled and the LFSR does not advance; overrides datak_i.
- scramble_enable_i  in  1  0 forces all bytes through unscrambled; the LFSR still advances as if enabled.
- lfsr_reset_i  in  1  reload the LFSR with the seed (EIEOS / block-alignment boundary).
- valid_o  out  1  output beat present.
- ready_i  in  1  downstream accepts when valid_o & ready_i.
- data_o  out  8*BYTES  scrambled symbols.
- datak_o  out  BYTES  registered copy of datak_i | skip_i.
- lfsr_state_o  out  23  current LFSR state, for debug and checking.

## Operation
- Seeds by LANE_NUM mod 8, for 0..7:
  - 0x1DBFBC, 0x0607BB, 0x1EC760, 0x18C0DB
  - 0x010F12, 0x19CFC9, 0x0277CE, 0x1BB807
- Polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form. The step function on state s for input bit d is:
  - key = s[22]
  - out = d ^ (key & en_byte)
  - s' = {s[21:0],1'b0} ^ (key ? 23'h210125 : 0)
- Bits are processed LSB first within a byte. Bytes are processed 0 to BYTES-1, chained combinationally through one state.
- For byte i:
  - skip_i[i]=1: no LFSR steps, byte passes through unchanged.
  - Otherwise: 8 LFSR steps; en_byte = scramble_enable_i & ~datak_i[i].
- LFSR update occurs only on an accepted beat (valid_i & ready_o); next state = state after the last non-skipped byte.
- lfsr_reset_i has priority over advance and is honoured whether or not a beat is accepted.
  - A beat accepted in the same cycle is scrambled with the pre-reset state.
  - The state is the seed the next cycle.
- Output stage is a single register: ready_o = ~valid_o | ready_i.
  - Accepted beat: load data_o/datak_o and set valid_o.
  - valid_o & ~ready_i: hold data_o, datak_o and valid_o stable.
  - valid_o & ready_i & ~valid_i: clear valid_o next cycle.
- Arithmetic is XOR only; no width growth. lfsr_state_o is exactly 23 bits.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert), values:
  - valid_o=0, data_o=0, datak_o=0, lfsr_state_o=seed.
  - ready_o=1 combinationally from valid_o=0.
- Latency: 1 cycle from accepted input to valid_o.
- Throughput: one beat per cycle while ready_i=1.
- ready_o is combinational from ready_i and valid_o only; there is no path from valid_i.
- Reset asserted mid-stream discards the in-flight beat. The first beat after release uses the seed.
- lfsr_reset_i held for several cycles keeps the state at the seed; beats accepted during that time after the first cycle use the seed.
- All-skip beat: output is produced and the state is unchanged.

## Test plan
- Reset, LANE_NUM=0 and LANE_NUM=9: lfsr_state_o = 0x1DBFBC and 0x0607BB respectively; valid_o=0, ready_o=1.
- scramble_enable_i=0, data_i=0xDEADBEEF, BYTES=4: data_o=0xDEADBEEF one cycle later; lfsr_state_o equals the bit-serial model after 32 steps from the seed.
- scramble_enable_i=1, data_i=0 for 8 beats: data_o equals the model keystream. Repeating with lfsr_reset_i pulsed after beat 4 makes beat 5 repeat beat 1's output.
- skip_i=4'b0101, datak_i=4'b0010, data_i=0x11223344:
  - bytes 0 and 2 pass unchanged; byte 1 passes unchanged.
  - byte 3 is scrambled with keystream bits 8..15.
  - state advances 16 bits.
- Backpressure: hold ready_i=0 for 3 cycles with valid_i=1. data_o holds, ready_o=0, lfsr_state_o is frozen. After release, beats emerge in order with no loss or duplication.
- Assert rst_n_i low mid-burst: valid_o drops immediately and lfsr_state_o returns to the seed asynchronously.
